// File: rtl/div_arbiter.sv
// Two-requester round-robin front end for a single shared signed divide unit.
// Owns operand capture, launch, timeout watchdog and result return.
module div_arbiter #(
   parameter int TIMEOUT = 64,
   parameter int W       = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req0,
   input  logic                req1,
   input  logic signed [W-1:0] a0,
   input  logic signed [W-1:0] b0,
   input  logic signed [W-1:0] a1,
   input  logic signed [W-1:0] b1,
   output logic                gnt0,
   output logic                gnt1,
   output logic                done0,
   output logic                done1,
   output logic signed [W-1:0] q,
   output logic signed [W-1:0] r,
   output logic                err,
   output logic                busy,
   output logic signed [W-1:0] div_A,
   output logic signed [W-1:0] div_B,
   output logic                div_start,
   output logic                div_rst,
   input  logic signed [W-1:0] div_Q,
   input  logic signed [W-1:0] div_R,
   input  logic                div_err,
   input  logic                div_done
);
   localparam int CW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic                last_q, last_d;
   logic [CW-1:0]       cnt_q, cnt_d;
   logic [1:0]          gnt_q, gnt_d;
   logic [1:0]          done_q, done_d;
   logic                start_q, start_d;
   logic                drst_q, drst_d;
   logic                busy_q, busy_d;
   logic                err_q, err_d;
   logic signed [W-1:0] q_q, q_d, r_q, r_d, a_q, a_d, b_q, b_d;

   logic [1:0]          req_m;
   logic                win;
   logic signed [W-1:0] a_sel, b_sel;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= S_IDLE;
         owner_q <= 1'b0;
         last_q  <= 1'b1;
         cnt_q   <= '0;
         gnt_q   <= '0;
         done_q  <= '0;
         start_q <= 1'b0;
         drst_q  <= 1'b1;
         busy_q  <= 1'b0;
         err_q   <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         last_q  <= last_d;
         cnt_q   <= cnt_d;
         gnt_q   <= gnt_d;
         done_q  <= done_d;
         start_q <= start_d;
         drst_q  <= drst_d;
         busy_q  <= busy_d;
         err_q   <= err_d;
         q_q     <= q_d;
         r_q     <= r_d;
         a_q     <= a_d;
         b_q     <= b_d;
      end
   end

   // A requester whose done pulse is on the bus still has req high this cycle;
   // mask it so it is not granted a second time before it can drop req.
   assign req_m = {req1, req0} & ~done_q;
   assign win   = (req_m == 2'b11) ? ~last_q : req_m[1];
   assign a_sel = win ? a1 : a0;
   assign b_sel = win ? b1 : b0;

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      last_d  = last_q;
      cnt_d   = cnt_q;
      gnt_d   = '0;
      done_d  = '0;
      start_d = 1'b0;
      drst_d  = 1'b0;
      err_d   = err_q;
      q_d     = q_q;
      r_d     = r_q;
      a_d     = a_q;
      b_d     = b_q;
      unique case (state_q)
         S_IDLE: begin
            if (|req_m) begin
               owner_d    = win;
               gnt_d[win] = 1'b1;
               a_d        = a_sel;
               b_d        = b_sel;
               if (b_sel == '0) begin
                  q_d     = '0;
                  r_d     = '0;
                  err_d   = 1'b1;
                  state_d = S_RESP;
               end else begin
                  start_d = 1'b1;
                  state_d = S_LAUNCH;
               end
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // div_done takes priority over a timeout on the same edge
            if (div_done) begin
               q_d     = div_Q;
               r_d     = div_R;
               err_d   = div_err;
               state_d = S_RESP;
            end else if (cnt_q == CW'(TIMEOUT - 1)) begin
               q_d     = '0;
               r_d     = '0;
               err_d   = 1'b1;
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_RESP: begin
            done_d[owner_q] = 1'b1;
            drst_d          = 1'b1;
            last_d          = owner_q;
            state_d         = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   assign gnt0      = gnt_q[0];
   assign gnt1      = gnt_q[1];
   assign done0     = done_q[0];
   assign done1     = done_q[1];
   assign q         = q_q;
   assign r         = r_q;
   assign err       = err_q;
   assign busy      = busy_q;
   assign div_A     = a_q;
   assign div_B     = b_q;
   assign div_start = start_q;
   assign div_rst   = drst_q;
endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 64, maximum WAIT cycles before an operation is aborted.
REQ-002 Parameter W, default 32, dividend/divisor/quotient/remainder width.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-low reset.
REQ-005 req0, req1  input  1 each  level request; held high until matching done pulse.
REQ-006 a0, b0, a1, b1  input  W each, signed  dividend/divisor per requester; stable while req high and before gnt.
REQ-007 gnt0, gnt1  output  1 each  one-cycle pulse: operands captured.
REQ-008 done0, done1  output  1 each  one-cycle pulse: q, r, err valid for that requester.
REQ-009 q, r  output  W each, signed  shared result bus.
REQ-010 err  output  1  divide error, divide-by-zero or timeout.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 div_A, div_B  output  W each, signed  operands to the shared divide unit.
REQ-013 div_start  output  1  launch pulse to divide unit.
REQ-014 div_rst  output  1  active-high reset to divide unit.
REQ-015 div_Q, div_R  input  W each, signed  divide unit results.
REQ-016 div_err, div_done  input  1 each  divide unit status.

Function
REQ-017 FSM states IDLE, LAUNCH, WAIT, RESP; all outputs registered.
REQ-018 IDLE: on an edge with a request sampled, latch the winner's a/b into div_A/div_B, set owner, pulse gnt(owner) next cycle, go to LAUNCH.
REQ-019 Arbitration round-robin: both requests high selects the requester not served last; last-served pointer resets to 1, so requester 0 wins the first tie.
REQ-020 Only one request high: that requester is granted regardless of pointer.
REQ-021 Divisor zero in IDLE: still grant, skip LAUNCH/WAIT, go directly to RESP with q=0, r=0, err=1, div_start never asserted.
REQ-022 LAUNCH: div_start=1 for exactly one cycle, then WAIT.
REQ-023 WAIT: cycle counter increments from 0 each cycle; div_done sampled high -> latch q=div_Q, r=div_R, err=div_err, go to RESP.
REQ-024 WAIT counter reaching TIMEOUT without div_done -> q=0, r=0, err=1, go to RESP.
REQ-025 div_done and timeout on the same edge: div_done wins and its results are used.
REQ-026 RESP: done(owner)=1 and div_rst=1 for exactly one cycle, pointer updated to owner, then IDLE.
REQ-027 q, r, err hold their values until the next RESP.
REQ-028 Requester dropping req after gnt: operation completes and done still pulses.
REQ-029 div_done outside WAIT is ignored.
REQ-030 Back-to-back: a pending request is granted on the first IDLE edge after RESP; minimum per-operation latency is req-sample to done = 3 cycles plus divide time.
REQ-031 gnt0/gnt1 and done0/done1 are never high simultaneously.

Reset
REQ-032 rst low on a clock edge: state IDLE, pointer=1, counter=0, gnt/done/div_start/busy/err=0, q=r=div_A=div_B=0, div_rst=1.
REQ-033 div_rst deasserts on the first edge after rst goes high, unless entering RESP.
REQ-034 Reset mid-operation aborts it with no done pulse; requests still high afterwards are re-arbitrated from IDLE.

Verification
REQ-035 req0 only, a0=100, b0=7, divider done after 10 cycles with Q=14, R=2 -> gnt0 one pulse, div_start one pulse, done0 with q=14, r=2, err=0.
REQ-036 req0 and req1 raised on the same edge after reset -> requester 0 served first, then requester 1 granted on the IDLE edge after done0; a second simultaneous pair is served 1 then 0 only if 0 was served last.
REQ-037 req1 with b1=0 -> gnt1, done1 two cycles later, q=0, r=0, err=1, div_start never high.
REQ-038 TIMEOUT=8 with divider never asserting div_done -> done pulse after 8 WAIT cycles with err=1, q=0, and div_rst high in the same cycle.
REQ-039 rst low during WAIT -> all outputs at reset values, no done pulse; req0 held -> re-granted after rst goes high.
REQ-040 div_done asserted while IDLE with no request -> no state change, no done pulse.
